calc_alu_sched: RTL and testbench
=================================

Name: calc_alu_sched

Overview:
- Multi-cycle arithmetic controller between the calculator click/entry logic and the display code outputs.
- Accepts two latched operands plus an operator code through a start/done handshake.
- Sequences an iterative shift-add multiplier and a restoring divider, and produces the result plus status flags.
- Replaces the single-cycle %, /, +, -, x evaluation so the operand width scales without long combinational paths.

Parameters:
- WIDTH, 7, operand and result width in bits; must be 4..16.
- CNT_W, 4, iteration counter width; must satisfy 2**CNT_W > WIDTH.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- op_a  in  WIDTH  first operand, unsigned.
- op_b  in  WIDTH  second operand, unsigned.
- op_code  in  7  operator: 97 %, 98 /, 99 +, 100 -, 101 x; any other value is invalid.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse; result and flags are valid from this cycle.
- result  out  WIDTH  result value (magnitude for subtraction).
- neg  out  1  subtraction result is negative.
- ovf  out  1  add carry-out, or product bits above WIDTH are nonzero.
- err  out  1  divide or modulo by zero, or invalid op_code.

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous and active-high.
- Reset values: busy=0, done=0, result=0, neg=0, ovf=0, err=0, state=IDLE, counter=0.
- States: IDLE, EXEC, FIN.
- Accept: start=1 in IDLE at edge k.
  - Latch op_a, op_b, op_code; clear neg/ovf/err; set busy=1; load counter.
  - Invalid op_code, or op_b==0 with % or /: go directly to FIN with err=1 and result=0.
  - Otherwise go to EXEC.
- EXEC, + and -: exactly 1 cycle.
  - +: result = (a+b) mod 2**WIDTH; ovf = carry-out.
  - -: if a>=b, result=a-b and neg=0; else result=b-a and neg=1.
- EXEC, x: WIDTH cycles of shift-add over an internal 2*WIDTH product register, LSB of b first.
  - result = low WIDTH bits; ovf = OR of the high WIDTH bits.
- EXEC, / and %: WIDTH cycles of restoring division, MSB first.
  - / returns the quotient; % returns the remainder.
- Counter: loads 0 on accept, increments once per EXEC cycle, and leaves EXEC when it reaches the latency minus 1.
- FIN: done=1 for exactly one cycle; busy deasserts in the same cycle; next state is IDLE.
- Latency: done is high in the cycle after edge k+L+1.
  - L=1 for + and -.
  - L=WIDTH for x, / and %.
  - L=0 for error cases.
- Hold: result, neg, ovf and err keep their value until the next accepted start; they are not cleared at done.
- start while busy (EXEC or FIN): ignored, never queued.
- start in the first IDLE cycle after FIN: accepted, so back-to-back operations are legal.
- rst together with start: reset wins.
- rst mid-operation: abort, return to IDLE next edge, all outputs to reset values, no done pulse.
- Operand changes after accept: no effect; only the latched copies are used.
- Arithmetic is unsigned throughout; no sign-extension of inputs.

Decomposition:
- Shared package/header calc_pkg holds:
  - opcode constants OP_MOD=97, OP_DIV=98, OP_ADD=99, OP_SUB=100, OP_MUL=101, OP_NONE=103;
  - state encodings S_IDLE, S_EXEC, S_FIN.
- The calculator entry logic consumes the same opcode constants.
- One sub-module: calc_div_step.
  - Combinational single restoring-division step: inputs partial remainder, divisor, next dividend bit; outputs new remainder and quotient bit.
  - calc_alu_sched instantiates it once and iterates it WIDTH times.
- Shift-add multiply stays inline.

Test Plan:
- Add: op_a=7, op_b=5, op_code=99, start at edge k -> done after edge k+2, result=12, neg=0, ovf=0, err=0; busy high for 2 cycles.
- Subtract and multiply:
  - op_a=3, op_b=8, op_code=100 -> result=5, neg=1.
  - Then back-to-back 9x9 (101) -> done after edge k'+WIDTH+1 (cycle 8 for WIDTH=7), result=81, ovf=0.
- Divide and modulo: 9/2 (98) -> result=4; then 9%2 (97) -> result=1; each takes WIDTH+1 cycles; err=0.
- Error cases:
  - 5/0 (98) -> done after edge k+1, err=1, result=0.
  - op_code=103 -> err=1.
  - WIDTH=4 with 9x9 -> result=1 (81 mod 16), ovf=1.
- Start while busy: start 9x9, pulse start with 1+1 at EXEC cycle 3 -> ignored; single done, result=81.
- Reset mid-operation: start 9/2, assert rst at EXEC cycle 2 -> next cycle all outputs 0, no done pulse; a following 2+2 returns 4 normally.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared calculator definitions: operator codes and scheduler state encodings.
// The entry logic and the arithmetic scheduler both import these.
package calc_pkg;

  localparam logic [6:0] OP_MOD  = 7'd97;
  localparam logic [6:0] OP_DIV  = 7'd98;
  localparam logic [6:0] OP_ADD  = 7'd99;
  localparam logic [6:0] OP_SUB  = 7'd100;
  localparam logic [6:0] OP_MUL  = 7'd101;
  localparam logic [6:0] OP_NONE = 7'd103;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  function automatic logic op_valid(input logic [6:0] op);
    return (op == OP_MOD) || (op == OP_DIV) || (op == OP_ADD) ||
           (op == OP_SUB) || (op == OP_MUL);
  endfunction

endpackage

// File: rtl/calc_div_step.sv
// One restoring-division step: shift in the next dividend bit and subtract the
// divisor when it fits.
module calc_div_step #(
  parameter int WIDTH = 7
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic [WIDTH-1:0] divisor,
  input  logic             bit_in,
  output logic [WIDTH-1:0] rem_out,
  output logic             q_bit
);

  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] diff;

  assign trial = {rem_in, bit_in};
  assign q_bit = (trial >= {1'b0, divisor});
  // When the subtraction is taken the true difference is below the divisor,
  // so the low WIDTH bits hold it exactly.
  assign diff    = trial[WIDTH-1:0] - divisor;
  assign rem_out = q_bit ? diff : trial[WIDTH-1:0];

endmodule

// File: rtl/calc_alu_sched.sv
// Multi-cycle arithmetic scheduler: + and - in one step, shift-add multiply and
// restoring divide/modulo over WIDTH steps, with a start/done handshake.
//
// state  | meaning
// S_IDLE | waiting for start; result and flags hold the last operation
// S_EXEC | iterating; counter tracks the step number
// S_FIN  | final cycle of busy; results and done are registered on exit
module calc_alu_sched
  import calc_pkg::*;
#(
  parameter int WIDTH = 7,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [6:0]       op_code,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             neg,
  output logic             ovf,
  output logic             err
);

  state_t               state, state_n;
  logic [CNT_W-1:0]     cnt, last;
  logic [WIDTH-1:0]     opa, opb, rem, quo, rem_n;
  logic [6:0]           opc;
  logic [2*WIDTH-1:0]   acc, mcand;
  logic [WIDTH:0]       sum;
  logic                 bad, q_bit;

  assign bad  = !op_valid(op_code) ||
                ((op_b == '0) && ((op_code == OP_DIV) || (op_code == OP_MOD)));
  assign last = ((opc == OP_ADD) || (opc == OP_SUB)) ? '0 : CNT_W'(WIDTH - 1);
  assign sum  = {1'b0, opa} + {1'b0, opb};

  calc_div_step #(.WIDTH(WIDTH)) u_div_step (
    .rem_in  (rem),
    .divisor (opb),
    .bit_in  (opa[WIDTH-1]),
    .rem_out (rem_n),
    .q_bit   (q_bit)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE: if (start) state_n = bad ? S_FIN : S_EXEC;
      S_EXEC: if (cnt == last) state_n = S_FIN;
      S_FIN:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      opa    <= '0;
      opb    <= '0;
      opc    <= '0;
      acc    <= '0;
      mcand  <= '0;
      rem    <= '0;
      quo    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      neg    <= 1'b0;
      ovf    <= 1'b0;
      err    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: if (start) begin
          opa   <= op_a;
          opb   <= op_b;
          opc   <= op_code;
          cnt   <= '0;
          acc   <= '0;
          mcand <= {{WIDTH{1'b0}}, op_a};
          rem   <= '0;
          quo   <= '0;
          busy  <= 1'b1;
          neg   <= 1'b0;
          ovf   <= 1'b0;
          err   <= bad;
          if (bad) result <= '0;
        end
        S_EXEC: begin
          cnt <= cnt + CNT_W'(1);
          if (opc == OP_MUL) begin
            if (opb[0]) acc <= acc + mcand;
            mcand <= mcand << 1;
            opb   <= opb >> 1;
          end else if ((opc == OP_DIV) || (opc == OP_MOD)) begin
            rem <= rem_n;
            quo <= {quo[WIDTH-2:0], q_bit};
            opa <= opa << 1;
          end
        end
        S_FIN: begin
          busy <= 1'b0;
          done <= 1'b1;
          if (!err) begin
            case (opc)
              OP_ADD: begin
                result <= sum[WIDTH-1:0];
                ovf    <= sum[WIDTH];
              end
              OP_SUB: begin
                result <= (opa >= opb) ? (opa - opb) : (opb - opa);
                neg    <= (opa < opb);
              end
              OP_MUL: begin
                result <= acc[WIDTH-1:0];
                ovf    <= |acc[2*WIDTH-1:WIDTH];
              end
              OP_DIV:  result <= quo;
              default: result <= rem;
            endcase
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_calc_alu_sched.sv
// Directed bench for calc_alu_sched: a cycle-level arithmetic model checked every
// cycle, plus literal expectations for the documented cases.
module tb_calc_alu_sched;
  import calc_pkg::*;

  localparam int W = 7;
  localparam int M = 1 << W;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] op_a = '0, op_b = '0;
  logic [6:0]   op_code = '0;
  logic         busy, done, neg, ovf, err;
  logic [W-1:0] result;

  logic         start4 = 1'b0;
  logic [3:0]   a4 = '0, b4 = '0;
  logic [6:0]   oc4 = '0;
  logic         busy4, done4, neg4, ovf4, err4;
  logic [3:0]   result4;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  calc_alu_sched #(.WIDTH(W), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .start(start), .op_a(op_a), .op_b(op_b),
    .op_code(op_code), .busy(busy), .done(done), .result(result),
    .neg(neg), .ovf(ovf), .err(err)
  );

  calc_alu_sched #(.WIDTH(4), .CNT_W(3)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .op_a(a4), .op_b(b4),
    .op_code(oc4), .busy(busy4), .done(done4), .result(result4),
    .neg(neg4), .ovf(ovf4), .err(err4)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Behavioural model: what the outputs must be, from the operator rules.
  bit m_busy = 0, m_done = 0;
  int done_edge = 0;
  int m_res = 0, p_res = 0;
  bit m_neg = 0, m_ovf = 0, m_err = 0, p_neg = 0, p_ovf = 0, p_err = 0;

  always @(posedge clk) begin
    int a, b, lat, t;
    cyc++;
    m_done = 0;
    if (rst) begin
      m_busy = 0; m_res = 0; m_neg = 0; m_ovf = 0; m_err = 0;
    end else if (m_busy) begin
      if (cyc == done_edge) begin
        m_busy = 0; m_done = 1;
        m_res = p_res; m_neg = p_neg; m_ovf = p_ovf; m_err = p_err;
      end
    end else if (start) begin
      a = int'(op_a); b = int'(op_b);
      p_res = 0; p_neg = 0; p_ovf = 0; p_err = 0; lat = W;
      case (op_code)
        OP_ADD: begin t = a + b; p_res = t % M; p_ovf = (t >= M); lat = 1; end
        OP_SUB: begin p_res = (a >= b) ? a - b : b - a; p_neg = (a < b); lat = 1; end
        OP_MUL: begin t = a * b; p_res = t % M; p_ovf = (t >= M); end
        OP_DIV: if (b == 0) begin p_err = 1; lat = 0; end else p_res = a / b;
        OP_MOD: if (b == 0) begin p_err = 1; lat = 0; end else p_res = a % b;
        default: begin p_err = 1; lat = 0; end
      endcase
      done_edge = cyc + lat + 1;
      m_busy = 1;
    end
  end

  always @(negedge clk) begin
    if (cyc > 0) begin
      chk("busy", busy, m_busy);
      chk("done", done, m_done);
      if (!m_busy) begin
        chk("result", result, m_res);
        chk("neg", neg, m_neg);
        chk("ovf", ovf, m_ovf);
        chk("err", err, m_err);
      end
    end
  end

  // Called at a negedge; returns at the negedge where done is seen.
  task automatic do_op(input int a, input int b, input logic [6:0] op,
                       input int exp_lat, input string name);
    int k;
    bit seen;
    op_a = W'(a); op_b = W'(b); op_code = op; start = 1'b1;
    k = cyc + 1;
    @(negedge clk);
    start = 1'b0;
    op_a = W'($urandom); op_b = W'($urandom); op_code = 7'($urandom_range(0, 127));
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (done) seen = 1;
      else @(negedge clk);
    end
    if (!seen) chk({name, " done timeout"}, 0, 1);
    else chk({name, " latency"}, cyc - k, exp_lat);
  endtask

  initial begin
    int k;
    bit seen;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset busy", busy, 0);
    chk("reset result", result, 0);
    chk("reset busy4", busy4, 0);
    rst = 1'b0;
    @(negedge clk);

    do_op(7, 5, OP_ADD, 2, "add");
    chk("add result", result, 12);
    chk("add ovf", ovf, 0);
    do_op(3, 8, OP_SUB, 2, "sub");
    chk("sub result", result, 5);
    chk("sub neg", neg, 1);
    do_op(9, 9, OP_MUL, 8, "mul");
    chk("mul result", result, 81);
    chk("mul ovf", ovf, 0);
    do_op(9, 2, OP_DIV, 8, "div");
    chk("div result", result, 4);
    do_op(9, 2, OP_MOD, 8, "mod");
    chk("mod result", result, 1);
    chk("mod err", err, 0);
    do_op(5, 0, OP_DIV, 1, "div0");
    chk("div0 err", err, 1);
    chk("div0 result", result, 0);
    do_op(4, 4, OP_NONE, 1, "badop");
    chk("badop err", err, 1);
    do_op(100, 50, OP_ADD, 2, "add carry");
    chk("add carry result", result, 22);
    chk("add carry ovf", ovf, 1);
    do_op(7, 7, OP_SUB, 2, "sub equal");
    chk("sub equal neg", neg, 0);
    do_op(127, 127, OP_MUL, 8, "mul big");
    chk("mul big result", result, 1);
    chk("mul big ovf", ovf, 1);
    do_op(127, 1, OP_DIV, 8, "div by 1");
    chk("div by 1 result", result, 127);
    do_op(5, 7, OP_MOD, 8, "mod small");
    chk("mod small result", result, 5);
    do_op(5, 0, OP_MOD, 1, "mod0");
    chk("mod0 err", err, 1);

    // start pulse while busy must be dropped
    op_a = 7'd9; op_b = 7'd9; op_code = OP_MUL; start = 1'b1;
    k = cyc + 1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    op_a = 7'd1; op_b = 7'd1; op_code = OP_ADD; start = 1'b1;
    @(negedge clk); start = 1'b0;
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (done) seen = 1;
      else @(negedge clk);
    end
    if (!seen) chk("busy-start done timeout", 0, 1);
    else chk("busy-start latency", cyc - k, 8);
    chk("busy-start result", result, 81);
    repeat (12) @(negedge clk);

    // reset mid-operation aborts without a done pulse
    op_a = 7'd9; op_b = 7'd2; op_code = OP_DIV; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    chk("abort busy", busy, 0);
    chk("abort done", done, 0);
    chk("abort result", result, 0);
    chk("abort flags", {neg, ovf, err}, 0);
    repeat (12) @(negedge clk);
    do_op(2, 2, OP_ADD, 2, "after abort");
    chk("after abort result", result, 4);

    // narrow instance: product wraps modulo 16
    a4 = 4'd9; b4 = 4'd9; oc4 = OP_MUL; start4 = 1'b1;
    k = cyc + 1;
    @(negedge clk); start4 = 1'b0;
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (done4) seen = 1;
      else @(negedge clk);
    end
    if (!seen) chk("w4 done timeout", 0, 1);
    else chk("w4 latency", cyc - k, 5);
    chk("w4 result", result4, 1);
    chk("w4 ovf", ovf4, 1);
    chk("w4 err", err4, 0);
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
